cache_bus_sequencer: RTL and testbench
======================================

// Module: cache_bus_sequencer
// PURPOSE
//  Sequences the shared memory bus of the L1 data cache between CPU accesses and bus snoops.
//  - Drives the writeback, fetch, rd and wr strobes into the cache datapath.
//  - Snoop hits on modified lines force a writeback.
//  - CPU misses trigger an optional victim writeback, then a line fill.
//  - Sits between the cache tag/array datapath and the system memory interface.
// PARAMETERS
//  BEATS          4   mem_ack beats per line transfer (writeback or fill), >=1
//  TIMEOUT_CYCLES 64  max cycles without mem_ack in a bus state (CACHE_SEQ_TIMEOUT_EN only)
// PORTS
//  clk           in   1  clock; all logic on posedge clk
//  reset         in   1  asynchronous, active-high reset
//  cpu_rd        in   1  CPU read request; held until cpu_done
//  cpu_wr        in   1  CPU write request; held until cpu_done
//  cpu_hit       in   1  tag hit for the current CPU address
//  cpu_dirty     in   1  victim line is modified
//  snoop         in   1  1-cycle snoop pulse from the bus
//  hit_modified  in   1  snoop address hits a modified line; valid with snoop
//  mem_ack       in   1  one beat of the current line transfer completed
//  writeback     out  1  line writeback in progress (snoop or victim)
//  fetch         out  1  line fill in progress
//  rd            out  1  cache array read strobe
//  wr            out  1  cache array write strobe
//  cpu_done      out  1  1-cycle pulse; the CPU access is complete
//  snoop_done    out  1  1-cycle pulse; the snoop has been serviced
//  snoop_ovf     out  1  sticky; a snoop arrived while one was already pending
//  busy          out  1  FSM not in IDLE
//  timeout_err   out  1  sticky watchdog flag (present only with CACHE_SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: every output is 0, the FSM is in IDLE, and the snoop pending flag, beat counter and fairness bit are cleared. Reset takes effect immediately, including mid-transfer.
//  - FSM states: IDLE, SNP_WB, LOOKUP, VIC_WB, FILL, ACCESS.
//  - Snoop capture, in any state:
//    - snoop && hit_modified sets snp_pend.
//    - If snp_pend is already set, snoop_ovf is set and the new snoop is dropped.
//    - snoop && !hit_modified: snoop_done pulses the next cycle; no FSM involvement.
//    - If that pulse collides with an SNP_WB completion, the SNP_WB pulse wins and the miss-pulse is delayed 1 cycle.
//  - IDLE arbitration:
//    - snp_pend wins, unless last_snp=1 and a CPU request is present. In that case the CPU goes first (fairness; last_snp is set on SNP_WB entry and cleared on LOOKUP entry).
//    - Otherwise, cpu_rd|cpu_wr -> LOOKUP.
//  - SNP_WB: writeback=1; count mem_ack up to BEATS. On the last beat: snoop_done pulse, snp_pend cleared, -> IDLE.
//  - LOOKUP (1 cycle): samples cpu_hit and cpu_dirty.
//    - hit -> ACCESS.
//    - miss && dirty -> VIC_WB.
//    - miss && clean -> FILL.
//  - VIC_WB: writeback=1 until BEATS mem_acks, then -> FILL.
//  - FILL: fetch=1 until BEATS mem_acks, then -> ACCESS.
//  - ACCESS (1 cycle): rd=cpu_rd, wr=cpu_wr&&!cpu_rd (read wins if both are set); cpu_done=1; -> IDLE.
//  - Outputs writeback and fetch are registered (Moore). cpu_done and snoop_done are registered 1-cycle pulses.
//  - Hit latency: request seen in IDLE -> cpu_done 2 cycles later.
//  - mem_ack outside SNP_WB/VIC_WB/FILL is ignored.
//  - Beat counter: $clog2(BEATS+1) bits; cleared on every state entry.
//  - Dropping cpu_rd and cpu_wr before cpu_done is illegal. The block still completes the sequence.
//  - A snoop arriving during a CPU sequence stays pending. It is serviced in the next IDLE, subject to fairness.
// CONFIGURATION
//  - `define CACHE_SEQ_TIMEOUT_EN:
//    - A watchdog counts cycles since the last mem_ack (or since state entry) in SNP_WB, VIC_WB or FILL.
//    - At TIMEOUT_CYCLES: timeout_err is set (sticky until reset) and the FSM returns to IDLE. No cpu_done or snoop_done is issued, and snp_pend is cleared.
//  - Without the macro: there is no watchdog and no timeout_err port; bus states wait indefinitely.
// TESTING
//  - Reset mid-FILL (beat 2 of 4) -> next cycle fetch=0, busy=0; a fresh cpu_rd with hit gives cpu_done 2 cycles later.
//  - cpu_rd with cpu_hit=1 -> LOOKUP, ACCESS; rd=1 and cpu_done=1 at cycle +2; writeback and fetch never asserted.
//  - cpu_wr with miss and dirty, BEATS=4 -> writeback for exactly 4 acks, then fetch for 4 acks, then wr=1 and cpu_done=1 on the cycle after the 8th ack.
//  - snoop+hit_modified during VIC_WB, then a second snoop+hit_modified -> snoop_ovf=1. After cpu_done: SNP_WB with 4 acks, snoop_done=1, snp_pend=0.
//  - snp_pend and cpu_rd both present after an SNP_WB (last_snp=1) -> CPU is served first (LOOKUP), then SNP_WB.
//  - CACHE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, FILL with no mem_ack -> timeout_err=1 at cycle 64, FSM in IDLE, no cpu_done.

Source files
------------

// File: rtl/cache_bus_sequencer.sv
// Shared-bus sequencer for the L1 data cache: CPU lookups, victim writebacks, line fills and snoop writebacks.
// Optional watchdog with timeout_err port is enabled by `define CACHE_SEQ_TIMEOUT_EN.
module cache_bus_sequencer #(
  parameter int BEATS          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_rd,
  input  logic cpu_wr,
  input  logic cpu_hit,
  input  logic cpu_dirty,
  input  logic snoop,
  input  logic hit_modified,
  input  logic mem_ack,
  output logic writeback,
  output logic fetch,
  output logic rd,
  output logic wr,
  output logic cpu_done,
  output logic snoop_done,
  output logic snoop_ovf,
  output logic busy
`ifdef CACHE_SEQ_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  localparam int BW = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SNP_WB,
    LOOKUP,
    VIC_WB,
    FILL,
    ACCESS
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          snp_pend_q, snp_pend_d;
  logic          last_snp_q, last_snp_d;
  logic          miss_pend_q, miss_pend_d;
  logic          snoop_ovf_q, snoop_ovf_d;
  logic          writeback_q, writeback_d;
  logic          fetch_q, fetch_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          cpu_done_q, cpu_done_d;
  logic          snoop_done_q, snoop_done_d;
  logic          busy_q, busy_d;

  logic          cpu_req, in_bus, last_ack, new_miss, snp_fin, pend_clr;

`ifdef CACHE_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;

  assign timeout_err = timeout_q;
`endif

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    snp_pend_d   = snp_pend_q;
    last_snp_d   = last_snp_q;
    snoop_ovf_d  = snoop_ovf_q;
    miss_pend_d  = 1'b0;
    snoop_done_d = 1'b0;
    snp_fin      = 1'b0;
    pend_clr     = 1'b0;
    cpu_req      = cpu_rd | cpu_wr;
    in_bus       = (state_q == SNP_WB) || (state_q == VIC_WB) || (state_q == FILL);
    last_ack     = in_bus && mem_ack && (beat_q == LAST_BEAT);
    new_miss     = snoop & ~hit_modified;

    if (in_bus && mem_ack) beat_d = beat_q + 1'b1;

    case (state_q)
      IDLE: begin
        // A CPU request overtakes a pending snoop only right after a snoop writeback.
        if (snp_pend_q && !(last_snp_q && cpu_req)) begin
          state_d    = SNP_WB;
          last_snp_d = 1'b1;
        end else if (cpu_req) begin
          state_d    = LOOKUP;
          last_snp_d = 1'b0;
        end
      end
      SNP_WB: begin
        if (last_ack) begin
          state_d  = IDLE;
          snp_fin  = 1'b1;
          pend_clr = 1'b1;
        end
      end
      LOOKUP: begin
        if (cpu_hit)        state_d = ACCESS;
        else if (cpu_dirty) state_d = VIC_WB;
        else                state_d = FILL;
      end
      VIC_WB:  if (last_ack) state_d = FILL;
      FILL:    if (last_ack) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CACHE_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    if (in_bus) begin
      if (mem_ack) begin
        wdog_d = '0;
      end else if (wdog_q == WDOG_LAST) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        pend_clr  = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
    if (state_d != state_q) wdog_d = '0;
`endif

    if (state_d != state_q) beat_d = '0;

    if (pend_clr) snp_pend_d = 1'b0;
    if (snoop && hit_modified) begin
      if (snp_pend_q) snoop_ovf_d = 1'b1;
      else            snp_pend_d  = 1'b1;
    end

    // A clean-snoop acknowledgement that collides with a writeback completion slips one cycle.
    if (snp_fin) begin
      snoop_done_d = 1'b1;
      miss_pend_d  = new_miss | miss_pend_q;
    end else begin
      snoop_done_d = new_miss | miss_pend_q;
      miss_pend_d  = new_miss & miss_pend_q;
    end

    writeback_d = (state_d == SNP_WB) || (state_d == VIC_WB);
    fetch_d     = (state_d == FILL);
    busy_d      = (state_d != IDLE);
    cpu_done_d  = (state_d == ACCESS);
    rd_d        = (state_d == ACCESS) && cpu_rd;
    wr_d        = (state_d == ACCESS) && cpu_wr && !cpu_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      snp_pend_q   <= 1'b0;
      last_snp_q   <= 1'b0;
      miss_pend_q  <= 1'b0;
      snoop_ovf_q  <= 1'b0;
      writeback_q  <= 1'b0;
      fetch_q      <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      cpu_done_q   <= 1'b0;
      snoop_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CACHE_SEQ_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      snp_pend_q   <= snp_pend_d;
      last_snp_q   <= last_snp_d;
      miss_pend_q  <= miss_pend_d;
      snoop_ovf_q  <= snoop_ovf_d;
      writeback_q  <= writeback_d;
      fetch_q      <= fetch_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cpu_done_q   <= cpu_done_d;
      snoop_done_q <= snoop_done_d;
      busy_q       <= busy_d;
`ifdef CACHE_SEQ_TIMEOUT_EN
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign writeback  = writeback_q;
  assign fetch      = fetch_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign cpu_done   = cpu_done_q;
  assign snoop_done = snoop_done_q;
  assign snoop_ovf  = snoop_ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cache_bus_sequencer.sv
// Self-checking bench for cache_bus_sequencer: a segment-queue model checked every cycle plus directed literal checks.
// The watchdog scenario runs only when CACHE_SEQ_TIMEOUT_EN is defined.
module tb_cache_bus_sequencer;

  localparam int BEATS = 4;
  localparam int S_SNP = 1, S_LOOK = 2, S_VIC = 3, S_FIL = 4, S_ACC = 5;

  logic clk = 1'b0;
  logic reset;
  logic cpu_rd, cpu_wr, cpu_hit, cpu_dirty, snoop, hit_modified, mem_ack;
  logic writeback, fetch, rd, wr, cpu_done, snoop_done, snoop_ovf, busy;
`ifdef CACHE_SEQ_TIMEOUT_EN
  logic timeout_err;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  bit ack_en = 1'b0;
  logic gen_ack = 1'b0;
  logic man_ack = 1'b0;
  int wb_acks = 0;
  int fill_acks = 0;
  int last_ack_cyc = 0;

  assign mem_ack = ack_en ? gen_ack : man_ack;

  cache_bus_sequencer #(.BEATS(BEATS), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_hit(cpu_hit),
    .cpu_dirty(cpu_dirty), .snoop(snoop), .hit_modified(hit_modified), .mem_ack(mem_ack),
    .writeback(writeback), .fetch(fetch), .rd(rd), .wr(wr), .cpu_done(cpu_done),
    .snoop_done(snoop_done), .snoop_ovf(snoop_ovf), .busy(busy)
`ifdef CACHE_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a queue of pending work segments; the head segment determines the outputs.
  int seg_q[$];
  int acks_left;
  int m_owed;
  bit m_pend, m_ovf, m_last_snp;
  bit e_wb, e_fetch, e_rd, e_wr, e_cdone, e_sdone, e_busy;

  task automatic model_clear();
    seg_q.delete();
    acks_left = 0; m_owed = 0;
    m_pend = 0; m_ovf = 0; m_last_snp = 0;
    e_wb = 0; e_fetch = 0; e_rd = 0; e_wr = 0; e_cdone = 0; e_sdone = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int head;
    bit moved, snp_fin, set_pend;
    head = (seg_q.size() == 0) ? 0 : seg_q[0];
    moved = 0; snp_fin = 0; set_pend = 0;
    case (head)
      0: begin
        if (m_pend && !(m_last_snp && (cpu_rd || cpu_wr))) begin
          seg_q.push_back(S_SNP); m_last_snp = 1; moved = 1;
        end else if (cpu_rd || cpu_wr) begin
          seg_q.push_back(S_LOOK); m_last_snp = 0; moved = 1;
        end
      end
      S_LOOK: begin
        void'(seg_q.pop_front());
        moved = 1;
        if (!cpu_hit) begin
          if (cpu_dirty) seg_q.push_back(S_VIC);
          seg_q.push_back(S_FIL);
        end
        seg_q.push_back(S_ACC);
      end
      S_ACC: begin
        void'(seg_q.pop_front());
        moved = 1;
      end
      default: begin
        if (mem_ack) begin
          acks_left--;
          if (acks_left == 0) begin
            void'(seg_q.pop_front());
            moved = 1;
            snp_fin = (head == S_SNP);
          end
        end
      end
    endcase
    if (moved) acks_left = BEATS;
    head = (seg_q.size() == 0) ? 0 : seg_q[0];
    e_wb    = (head == S_SNP) || (head == S_VIC);
    e_fetch = (head == S_FIL);
    e_busy  = (head != 0);
    e_cdone = (head == S_ACC);
    e_rd    = e_cdone && cpu_rd;
    e_wr    = e_cdone && cpu_wr && !cpu_rd;
    if (snoop && hit_modified) begin
      if (m_pend) m_ovf = 1;
      else set_pend = 1;
    end
    if (snp_fin) m_pend = 0;
    if (set_pend) m_pend = 1;
    if (snoop && !hit_modified) m_owed++;
    e_sdone = 0;
    if (snp_fin) e_sdone = 1;
    else if (m_owed > 0) begin
      e_sdone = 1;
      m_owed--;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    if (check_en && !reset) begin
      check_output("writeback", writeback, e_wb);
      check_output("fetch", fetch, e_fetch);
      check_output("rd", rd, e_rd);
      check_output("wr", wr, e_wr);
      check_output("cpu_done", cpu_done, e_cdone);
      check_output("snoop_done", snoop_done, e_sdone);
      check_output("snoop_ovf", snoop_ovf, m_ovf);
      check_output("busy", busy, e_busy);
    end
  end

  // Memory-side responder: acknowledges every other cycle while a line transfer is active.
  always @(negedge clk) begin
    if (ack_en) begin
      if (writeback || fetch) begin
        gen_ack = ~gen_ack;
        if (gen_ack) begin
          if (writeback) wb_acks++;
          else fill_acks++;
          last_ack_cyc = cyc;
        end
      end else begin
        gen_ack = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic r, input logic w, input logic h, input logic d);
    cpu_rd = r; cpu_wr = w; cpu_hit = h; cpu_dirty = d;
  endtask

  task automatic pulse_snoop(input logic hm);
    snoop = 1'b1; hit_modified = hm;
    @(negedge clk);
    snoop = 1'b0; hit_modified = 1'b0;
  endtask

  task automatic wait_for(input int which, input int limit, output int waited);
    logic v;
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      case (which)
        0: v = cpu_done;
        1: v = writeback;
        2: v = fetch;
        3: v = snoop_done;
        default: v = ~busy;
      endcase
      if (v === 1'b1) break;
      if (waited >= limit) begin
        tests++; fails++;
        $display("[TB] FAIL wait_%0d: still low after %0d cycles, required 1", which, limit);
        break;
      end
    end
  endtask

  initial begin
    int n, w0, f0, c0;
    apply_stimulus(0, 0, 0, 0);
    snoop = 0; hit_modified = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_writeback", writeback, 0);
    check_output("rst_fetch", fetch, 0);
    check_output("rst_cpu_done", cpu_done, 0);
    check_output("rst_snoop_ovf", snoop_ovf, 0);
    check_output("rst_busy", busy, 0);
`ifdef CACHE_SEQ_TIMEOUT_EN
    check_output("rst_timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    // Read hit: done two cycles after the request appears.
    c0 = cyc;
    apply_stimulus(1, 0, 1, 0);
    wait_for(0, 10, n);
    check_output("hit_latency", cyc - c0, 2);
    check_output("hit_rd", rd, 1);
    check_output("hit_wr", wr, 0);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);

    // Read and write together: read wins.
    apply_stimulus(1, 1, 1, 0);
    wait_for(0, 10, n);
    check_output("both_rd", rd, 1);
    check_output("both_wr", wr, 0);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);

    // Stray acks while idle are ignored.
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    check_output("stray_ack_busy", busy, 0);
    man_ack = 1'b0;

    // Write miss to a dirty line: victim writeback then fill.
    ack_en = 1'b1;
    w0 = wb_acks; f0 = fill_acks;
    apply_stimulus(0, 1, 0, 1);
    wait_for(0, 100, n);
    check_output("vic_wb_acks", wb_acks - w0, 4);
    check_output("fill_acks", fill_acks - f0, 4);
    check_output("miss_wr", wr, 1);
    check_output("done_after_8th_ack", cyc - last_ack_cyc, 1);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);

    // Two modified-line snoops during a victim writeback: the second overflows.
    apply_stimulus(1, 0, 0, 1);
    wait_for(1, 10, n);
    pulse_snoop(1);
    pulse_snoop(1);
    check_output("snoop_ovf_set", snoop_ovf, 1);
    wait_for(0, 100, n);
    apply_stimulus(0, 0, 0, 0);
    w0 = wb_acks;
    wait_for(3, 100, n);
    check_output("snp_wb_acks", wb_acks - w0, 4);
    check_output("snp_done_idle", busy, 0);

    // Fairness: right after a snoop writeback, a CPU request beats a new pending snoop.
    pulse_snoop(1);
    apply_stimulus(1, 0, 1, 0);
    @(negedge clk);
    check_output("fair_cpu_first_busy", busy, 1);
    check_output("fair_cpu_first_wb", writeback, 0);
    wait_for(0, 10, n);
    check_output("fair_rd", rd, 1);
    apply_stimulus(0, 0, 0, 0);
    wait_for(1, 10, n);
    wait_for(3, 100, n);
    check_output("fair_snp_done", snoop_done, 1);

    // Clean snoop: acknowledged on the next cycle.
    pulse_snoop(0);
    check_output("clean_snoop_done", snoop_done, 1);
    @(negedge clk);
    check_output("clean_snoop_single", snoop_done, 0);

    // Clean snoop colliding with a snoop writeback completion.
    ack_en = 1'b0;
    pulse_snoop(1);
    wait_for(1, 5, n);
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    snoop = 1'b1; hit_modified = 1'b0;
    @(negedge clk);
    snoop = 1'b0; man_ack = 1'b0;
    check_output("collide_first", snoop_done, 1);
    @(negedge clk);
    check_output("collide_delayed", snoop_done, 1);
    @(negedge clk);
    check_output("collide_end", snoop_done, 0);

    // Reset in the middle of a fill.
    apply_stimulus(1, 0, 0, 0);
    wait_for(2, 5, n);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("midfill_rst_fetch", fetch, 0);
    check_output("midfill_rst_busy", busy, 0);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    apply_stimulus(1, 0, 1, 0);
    wait_for(0, 10, n);
    check_output("post_rst_latency", cyc - c0, 2);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);

    // Read miss to a clean line: fill only.
    ack_en = 1'b1;
    w0 = wb_acks; f0 = fill_acks;
    apply_stimulus(1, 0, 0, 0);
    wait_for(0, 100, n);
    check_output("clean_miss_wb_acks", wb_acks - w0, 0);
    check_output("clean_miss_fill_acks", fill_acks - f0, 4);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);

`ifdef CACHE_SEQ_TIMEOUT_EN
    // Fill with no acks: watchdog aborts without completing the access.
    check_en = 1'b0;
    ack_en = 1'b0;
    man_ack = 1'b0;
    apply_stimulus(1, 0, 0, 0);
    wait_for(2, 5, n);
    wait_for(4, 100, n);
    check_output("timeout_cycles", n, 64);
    check_output("timeout_err", timeout_err, 1);
    check_output("timeout_no_done", cpu_done, 0);
    apply_stimulus(0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
